// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameter values for the run controller.
package run_ctrl_pkg;

  // Phase encoding of the run controller FSM.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StWork  = 2'b10,
    StStop  = 2'b11
  } run_state_e;

  localparam int unsigned DbNDef    = 16;
  localparam int unsigned PulseWDef = 1;
  localparam int unsigned TmoWDef   = 24;
  localparam int unsigned RunWDef   = 8;

endpackage

// File: rtl/debounce.sv
// Push-button debouncer.
// Ports: clk_i, reset_i (async, active high), btn_i (raw, asynchronous), db_o (debounced level).
// The raw input is synchronised by two flops; db_o follows it only after the synchronised
// value has differed from db_o for 2^N consecutive cycles.
module debounce #(
  parameter int unsigned N = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic db_o
);

  logic [1:0]   sync_q;
  logic [N-1:0] cnt_q, cnt_d;
  logic         db_q, db_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_q[1] != db_q) begin
      if (&cnt_q) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/run_ctrl_edge_rise.sv
// Registered rising-edge detector, 1 bit.
// Ports: clk_i, reset_i (async, active high), d_i (level), rise_o (high in the first cycle d_i is
// high after being low).
module edge_rise (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/run_ctrl.sv
// Start/work/stop run controller for the debug front end.
// Ports: clk_i, reset_i (async, active high), btn_start_i / btn_stop_i (raw buttons),
// tmo_limit_i (WORK timeout in cycles, 0 = none), start_o / working_o / stop_o (one-hot phase),
// timeout_o (sticky auto-stop flag), run_cnt_o (completed runs, wrapping).
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DB_N    = DbNDef,
  parameter int unsigned PULSE_W = PulseWDef,
  parameter int unsigned TMO_W   = TmoWDef,
  parameter int unsigned RUN_W   = RunWDef
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             btn_start_i,
  input  logic             btn_stop_i,
  input  logic [TMO_W-1:0] tmo_limit_i,
  output logic             start_o,
  output logic             working_o,
  output logic             stop_o,
  output logic             timeout_o,
  output logic [RUN_W-1:0] run_cnt_o
);

  localparam int unsigned PcW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [PcW-1:0] PulseLoad = PcW'(PULSE_W - 1);

  logic db_s, db_p, ev_s, ev_p;

  debounce #(.N(DB_N)) u_db_start (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (btn_start_i),
    .db_o    (db_s)
  );

  debounce #(.N(DB_N)) u_db_stop (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (btn_stop_i),
    .db_o    (db_p)
  );

  edge_rise u_edge_start (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (db_s),
    .rise_o  (ev_s)
  );

  edge_rise u_edge_stop (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (db_p),
    .rise_o  (ev_p)
  );

  run_state_e       state_q, state_d;
  logic [PcW-1:0]   pulse_q, pulse_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [TMO_W-1:0] tmo_lim_q, tmo_lim_d;
  logic             timeout_q, timeout_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             tmo_hit;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      pulse_q   <= '0;
      tmo_cnt_q <= '0;
      tmo_lim_q <= '0;
      timeout_q <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_lim_q <= tmo_lim_d;
      timeout_q <= timeout_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Hit on the last WORK cycle so that WORK lasts exactly tmo_lim_q cycles.
  assign tmo_hit = (tmo_lim_q != '0) && (tmo_cnt_q == tmo_lim_q - TMO_W'(1));

  always_comb begin
    state_d   = state_q;
    pulse_d   = pulse_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_lim_d = tmo_lim_q;
    timeout_d = timeout_q;
    run_cnt_d = run_cnt_q;
    unique case (state_q)
      StIdle: begin
        // A simultaneous stop press cancels the start.
        if (ev_s && !ev_p) begin
          state_d   = StStart;
          timeout_d = 1'b0;
          pulse_d   = PulseLoad;
        end
      end
      StStart: begin
        if (pulse_q == '0) begin
          state_d   = StWork;
          tmo_lim_d = tmo_limit_i;
          tmo_cnt_d = '0;
        end else begin
          pulse_d = pulse_q - 1'b1;
        end
      end
      StWork: begin
        if (!(&tmo_cnt_q)) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        // User stop takes priority over a coincident timeout.
        if (ev_p) begin
          state_d = StStop;
          pulse_d = PulseLoad;
        end else if (tmo_hit) begin
          state_d   = StStop;
          pulse_d   = PulseLoad;
          timeout_d = 1'b1;
        end
      end
      StStop: begin
        if (pulse_q == '0) begin
          state_d   = StIdle;
          run_cnt_d = run_cnt_q + 1'b1;
        end else begin
          pulse_d = pulse_q - 1'b1;
        end
      end
    endcase
  end

  assign start_o   = (state_q == StStart);
  assign working_o = (state_q == StWork);
  assign stop_o    = (state_q == StStop);
  assign timeout_o = timeout_q;
  assign run_cnt_o = run_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: DB_N=4, PULSE_W=3, TMO_W=8, RUN_W=2.
module tb_run_ctrl;

  localparam int unsigned DbN    = 4;
  localparam int unsigned PulseW = 3;
  localparam int unsigned TmoW   = 8;
  localparam int unsigned RunW   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            btn_start, btn_stop;
  logic [TmoW-1:0] tmo_limit;
  logic            start_o, working_o, stop_o, timeout_o;
  logic [RunW-1:0] run_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;
  int runs   = 0;

  run_ctrl #(
    .DB_N    (DbN),
    .PULSE_W (PulseW),
    .TMO_W   (TmoW),
    .RUN_W   (RunW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .btn_start_i (btn_start),
    .btn_stop_i  (btn_stop),
    .tmo_limit_i (tmo_limit),
    .start_o     (start_o),
    .working_o   (working_o),
    .stop_o      (stop_o),
    .timeout_o   (timeout_o),
    .run_cnt_o   (run_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [2:0] ph();
    return {start_o, working_o, stop_o};
  endfunction

  task automatic set_btn(input bit which, input logic v);
    if (which) btn_stop = v;
    else btn_start = v;
  endtask

  task automatic press(input bit which, input bit bouncy);
    if (bouncy) begin
      repeat (20) begin
        @(negedge clk);
        set_btn(which, logic'($urandom_range(0, 1)));
      end
    end
    @(negedge clk);
    set_btn(which, 1'b1);
  endtask

  task automatic release_btn(input bit which);
    @(negedge clk);
    set_btn(which, 1'b0);
    repeat (30) @(negedge clk);
  endtask

  task automatic wait_phase(input logic [2:0] pat, input string tag);
    int waited = 0;
    while (ph() != pat && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check(tag, int'(ph()), int'(pat));
  endtask

  task automatic measure(input logic [2:0] pat, output int n);
    n = 0;
    while (ph() == pat && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_not(input logic [2:0] pat, input int cycles, output int busy);
    busy = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ph() != pat) busy++;
    end
  endtask

  initial begin
    int n, k, busy;
    reset     = 1'b1;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    tmo_limit = '0;
    repeat (3) @(negedge clk);
    check("reset phase", int'(ph()), 0);
    check("reset timeout", int'(timeout_o), 0);
    check("reset run_cnt", int'(run_cnt_o), 0);
    reset = 1'b0;

    // Basic run with no timeout.
    press(0, 1);
    wait_phase(3'b100, "basic start seen");
    measure(3'b100, n);
    check("basic start width", n, 3);
    check("basic working follows", int'(ph()), 3'b010);
    release_btn(0);
    check("basic still working", int'(ph()), 3'b010);
    press(1, 1);
    wait_phase(3'b001, "basic stop seen");
    measure(3'b001, n);
    check("basic stop width", n, 3);
    check("basic back to idle", int'(ph()), 0);
    runs = (runs + 1) % 4;
    check("basic run_cnt", int'(run_cnt_o), runs);
    check("basic timeout", int'(timeout_o), 0);
    release_btn(1);

    // Held start must not retrigger.
    press(0, 1);
    wait_phase(3'b010, "held working");
    press(1, 0);
    wait_phase(3'b001, "held stop");
    wait_phase(3'b000, "held idle");
    runs = (runs + 1) % 4;
    count_not(3'b000, 100, busy);
    check("held start no retrigger", busy, 0);
    check("held run_cnt", int'(run_cnt_o), runs);
    release_btn(1);
    release_btn(0);
    press(0, 1);
    wait_phase(3'b100, "repress start");
    wait_phase(3'b010, "repress working");
    release_btn(0);
    press(1, 0);
    wait_phase(3'b000, "repress idle");
    runs = (runs + 1) % 4;
    check("repress run_cnt", int'(run_cnt_o), runs);
    release_btn(1);

    // Timeout after 10 WORK cycles.
    tmo_limit = 8'd10;
    press(0, 1);
    wait_phase(3'b100, "tmo start");
    measure(3'b100, n);
    check("tmo start width", n, 3);
    measure(3'b010, n);
    check("tmo working width", n, 10);
    measure(3'b001, n);
    check("tmo stop width", n, 3);
    check("tmo idle", int'(ph()), 0);
    check("tmo flag set", int'(timeout_o), 1);
    runs = (runs + 1) % 4;
    check("tmo run_cnt", int'(run_cnt_o), runs);
    release_btn(0);
    check("tmo flag sticky", int'(timeout_o), 1);
    tmo_limit = '0;
    press(0, 1);
    wait_phase(3'b100, "clear start");
    check("tmo flag cleared", int'(timeout_o), 0);

    // Start pressed during WORK is ignored.
    wait_phase(3'b010, "ign working");
    release_btn(0);
    press(0, 1);
    count_not(3'b010, 60, busy);
    check("start in work ignored", busy, 0);
    release_btn(0);
    press(1, 0);
    wait_phase(3'b000, "ign idle");
    runs = (runs + 1) % 4;
    check("ign run_cnt", int'(run_cnt_o), runs);
    release_btn(1);

    // Start and stop edges in the same IDLE cycle.
    @(negedge clk);
    btn_start = 1'b1;
    btn_stop  = 1'b1;
    count_not(3'b000, 80, busy);
    check("simul stays idle", busy, 0);
    check("simul run_cnt", int'(run_cnt_o), runs);
    @(negedge clk);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    repeat (30) @(negedge clk);

    // Stop edge in the same cycle as the timeout hit. Button latency k is the same for
    // both buttons, so pressing stop 3+60 cycles after start lands on the hit cycle.
    tmo_limit = 8'd60;
    @(negedge clk);
    btn_start = 1'b1;
    k = 0;
    while (!start_o && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("coin start seen", int'(start_o), 1);
    repeat (63 - k) @(negedge clk);
    btn_stop = 1'b1;
    measure(3'b010, n);
    check("coin working width", 60 - k + n, 60);
    measure(3'b001, n);
    check("coin stop width", n, 3);
    check("coin timeout clear", int'(timeout_o), 0);
    runs = (runs + 1) % 4;
    check("coin run_cnt", int'(run_cnt_o), runs);
    release_btn(0);
    release_btn(1);

    // Reset mid-WORK.
    tmo_limit = '0;
    press(0, 1);
    wait_phase(3'b010, "rst working");
    release_btn(0);
    #2 reset = 1'b1;
    #1;
    check("rst phase", int'(ph()), 0);
    check("rst run_cnt", int'(run_cnt_o), 0);
    check("rst timeout", int'(timeout_o), 0);
    @(negedge clk);
    reset = 1'b0;
    runs  = 0;
    count_not(3'b000, 30, busy);
    check("rst no stop pulse", busy, 0);

    // Counter wrap with a 2-bit run counter.
    tmo_limit = 8'd3;
    for (int i = 0; i < 4; i++) begin
      press(0, 1);
      wait_phase(3'b100, "wrap start");
      release_btn(0);
      check("wrap idle", int'(ph()), 0);
      check("wrap run_cnt", int'(run_cnt_o), (i + 1) % 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Parametrised start/work/stop run controller for the debug front end.
- Two push buttons are debounced and edge-detected; the controller then sequences START, WORK and STOP phases with configurable pulse widths.
- Adds an optional WORK timeout (auto-stop), a sticky timeout flag and a completed-run counter.
- Drives downstream capture/transmit logic through one-hot phase outputs.

Parameters:
- DB_N, 16, counter width passed to each debounce instance.
- PULSE_W, 1, cycles that start and stop are each held high (≥1).
- TMO_W, 24, width of the WORK timeout counter and the tmo_limit port.
- RUN_W, 8, width of the completed-run counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_start  in  1  raw start button, asynchronous and bouncy.
- btn_stop  in  1  raw stop button, asynchronous and bouncy.
- tmo_limit  in  TMO_W  WORK timeout in cycles; 0 disables the timeout.
- start  out  1  high for PULSE_W cycles on entry to a run.
- working  out  1  high throughout WORK.
- stop  out  1  high for PULSE_W cycles at the end of a run.
- timeout  out  1  sticky; set when a run ends by timeout.
- run_cnt  out  RUN_W  number of completed runs; wraps modulo 2^RUN_W.

Behaviour:
- Reset, asynchronous and active-high:
  - state = IDLE.
  - start, working, stop and timeout = 0.
  - run_cnt = 0.
  - Edge-detect registers = 0.
  - Pulse and timeout counters = 0.
  - Reset asserted mid-run aborts immediately, with no stop pulse.
- Inputs: each button passes through one debounce instance, giving db_s and db_p.
  - db_q registers the debounced level.
  - Rising edges are defined as ev_s = db_s & ~db_q_s and ev_p = db_p & ~db_q_p.
  - Only edges act. A held button never retriggers; it must be released (db low) and pressed again.
- States: IDLE, START, WORK, STOP. Outputs decode from the state register: start = START, working = WORK, stop = STOP.
- IDLE:
  - ev_s & ~ev_p goes to START.
  - ev_s & ev_p in the same cycle: stop wins, stay in IDLE.
  - ev_p alone is ignored.
  - On any START entry: clear timeout, load pulse_cnt = PULSE_W-1.
- START:
  - Both button events are ignored.
  - When pulse_cnt = 0, go to WORK; otherwise decrement.
  - On WORK entry: latch tmo_limit into tmo_lim_q and clear tmo_cnt = 0. A later tmo_limit change does not affect the current run.
- WORK:
  - tmo_cnt increments each cycle and saturates at all-ones.
  - ev_p goes to STOP.
  - If tmo_lim_q != 0 and tmo_cnt == tmo_lim_q-1, go to STOP and set timeout. WORK therefore lasts exactly tmo_limit cycles.
  - If ev_p and the timeout hit occur in the same cycle, go to STOP with timeout = 0 (the user stop wins).
  - ev_s is ignored.
  - On STOP entry: load pulse_cnt = PULSE_W-1.
- STOP:
  - Events are ignored.
  - When pulse_cnt = 0, go to IDLE and increment run_cnt on that transition, wrapping from all-ones to 0.
- Latency: an edge in cycle n gives the state change, and hence output assertion, at cycle n+1.
  - start is high on cycles n+1 through n+PULSE_W.
  - working rises at n+PULSE_W+1.
- Exactly one of start, working and stop is high at a time outside IDLE.
- timeout stays set through IDLE until the next accepted start.

Decomposition:
- Package run_ctrl_pkg:
  - State encoding localparams: IDLE=2'b00, START=2'b01, WORK=2'b10, STOP=2'b11.
  - Default parameter constants.
- Sub-modules: reuse the existing debounce twice. One new sub-module, edge_rise (registered rising-edge detector, 1 bit), instantiated per button.
- The FSM and counters stay in run_ctrl.

Test Plan:
- Bench setup for all cases: DB_N=4, PULSE_W=3, TMO_W=8.
- Basic run, tmo_limit=0:
  - Press start (bouncy for 20 cycles, then held) → 3 start cycles, then working.
  - Press stop → 3 stop cycles, then IDLE; run_cnt 0→1; timeout=0.
- Held start:
  - Keep btn_start high after a run completes → no second run.
  - Release, press again → new run starts.
- Timeout, tmo_limit=10:
  - Start, no stop → working high exactly 10 cycles, then stop for 3 cycles; timeout=1, held in IDLE.
  - Next start clears timeout.
- Simultaneous events:
  - ev_s and ev_p in the same IDLE cycle → stays IDLE.
  - ev_p in the same cycle as the timeout hit → STOP, timeout=0.
  - Start pressed during WORK → ignored.
- Reset mid-WORK → all outputs 0 immediately, no stop pulse, run_cnt=0.
- Wrap with RUN_W=2: four completed runs → run_cnt 1,2,3,0.
